fe_fetch: RTL

- Front-end fetch stage. Owns the architectural fetch PC register and issues instruction-memory requests.
- Buffers returned instructions in a small in-order queue for decode.
- Sits directly downstream of the next-PC selector. It registers pc_next_i and feeds back pc_o, pc_2_o and stall_o.
- Handles branch redirect flushes by discarding wrong-path instructions, both queued and in flight.

---
 rtl/fe_fetch.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fe_fetch.sv
// Front-end fetch stage: owns the fetch PC, issues instruction-memory requests and
// buffers in-order responses for decode, discarding wrong-path work on a redirect.
module fe_fetch #(
    parameter int unsigned WORD_SIZE_P   = 16,
    parameter int unsigned QUEUE_DEPTH_P = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [WORD_SIZE_P-1:0] pc_next_i,
    input  logic                   flush_i,
    output logic [WORD_SIZE_P-1:0] pc_o,
    output logic [WORD_SIZE_P-1:0] pc_2_o,
    output logic                   stall_o,
    output logic                   imem_req_v_o,
    output logic [WORD_SIZE_P-1:0] imem_req_addr_o,
    input  logic                   imem_req_ready_i,
    input  logic                   imem_resp_v_i,
    input  logic [WORD_SIZE_P-1:0] imem_resp_data_i,
    output logic                   fe_v_o,
    output logic [WORD_SIZE_P-1:0] fe_instr_o,
    output logic [WORD_SIZE_P-1:0] fe_pc_o,
    input  logic                   fe_ready_i
);

    localparam int unsigned CntW = $clog2(QUEUE_DEPTH_P + 1);
    localparam int unsigned PtrW = (QUEUE_DEPTH_P > 1) ? $clog2(QUEUE_DEPTH_P) : 1;

    typedef logic [CntW-1:0]        cnt_t;
    typedef logic [CntW:0]          sum_t;
    typedef logic [PtrW-1:0]        ptr_t;
    typedef logic [WORD_SIZE_P-1:0] word_t;

    localparam ptr_t  LastPtr = ptr_t'(QUEUE_DEPTH_P - 1);
    localparam sum_t  DepthS  = sum_t'(QUEUE_DEPTH_P);
    localparam word_t PcInc   = {{(WORD_SIZE_P - 2){1'b0}}, 2'b10};

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    word_t pc_q, pc_d;
    cnt_t  out_cnt_q, out_cnt_d;
    cnt_t  drop_cnt_q, drop_cnt_d;
    cnt_t  q_cnt_q, q_cnt_d;
    ptr_t  if_wptr_q, if_wptr_d, if_rptr_q, if_rptr_d;
    ptr_t  q_wptr_q, q_wptr_d, q_rptr_q, q_rptr_d;
    word_t if_pc_q   [QUEUE_DEPTH_P];
    word_t if_pc_d   [QUEUE_DEPTH_P];
    word_t q_instr_q [QUEUE_DEPTH_P];
    word_t q_instr_d [QUEUE_DEPTH_P];
    word_t q_pc_q    [QUEUE_DEPTH_P];
    word_t q_pc_d    [QUEUE_DEPTH_P];

    logic credit_ok, accept, resp_take, resp_drop, push, pop;

    // Dropped-but-pending responses still hold credit until they return.
    assign credit_ok = (sum_t'(out_cnt_q) + sum_t'(q_cnt_q)) < DepthS;
    assign imem_req_v_o = reset_n_i & ~flush_i & credit_ok;
    assign accept       = imem_req_v_o & imem_req_ready_i;
    assign stall_o      = ~reset_n_i | (~accept & ~flush_i);

    assign resp_take = reset_n_i & imem_resp_v_i & (out_cnt_q != '0);
    assign resp_drop = resp_take & (flush_i | (drop_cnt_q != '0));
    assign push      = resp_take & ~resp_drop;

    assign fe_v_o = reset_n_i & (q_cnt_q != '0);
    assign pop    = fe_v_o & fe_ready_i & ~flush_i;

    assign pc_o            = pc_q;
    assign pc_2_o          = pc_q + PcInc;
    assign imem_req_addr_o = pc_q;
    assign fe_instr_o      = q_instr_q[q_rptr_q];
    assign fe_pc_o         = q_pc_q[q_rptr_q];

    always_comb begin
        pc_d       = pc_next_i;
        out_cnt_d  = out_cnt_q + cnt_t'(accept) - cnt_t'(resp_take);
        drop_cnt_d = drop_cnt_q;
        if_wptr_d  = if_wptr_q;
        if_rptr_d  = if_rptr_q;
        if_pc_d    = if_pc_q;
        q_wptr_d   = q_wptr_q;
        q_rptr_d   = q_rptr_q;
        q_cnt_d    = q_cnt_q;
        q_instr_d  = q_instr_q;
        q_pc_d     = q_pc_q;

        if (accept) begin
            if_pc_d[if_wptr_q] = pc_q;
            if_wptr_d          = ptr_inc(if_wptr_q);
        end
        if (resp_take) begin
            if_rptr_d = ptr_inc(if_rptr_q);
        end

        if (flush_i) begin
            // Everything still in flight is wrong-path; the arriving one is dropped now.
            drop_cnt_d = out_cnt_q - cnt_t'(resp_take);
            q_wptr_d   = '0;
            q_rptr_d   = '0;
            q_cnt_d    = '0;
        end else begin
            if (resp_take && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
            if (push) begin
                q_instr_d[q_wptr_q] = imem_resp_data_i;
                q_pc_d[q_wptr_q]    = if_pc_q[if_rptr_q];
                q_wptr_d            = ptr_inc(q_wptr_q);
            end
            if (pop) begin
                q_rptr_d = ptr_inc(q_rptr_q);
            end
            q_cnt_d = q_cnt_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            pc_q       <= '0;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            q_cnt_q    <= '0;
            if_wptr_q  <= '0;
            if_rptr_q  <= '0;
            q_wptr_q   <= '0;
            q_rptr_q   <= '0;
        end else begin
            pc_q       <= pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            q_cnt_q    <= q_cnt_d;
            if_wptr_q  <= if_wptr_d;
            if_rptr_q  <= if_rptr_d;
            q_wptr_q   <= q_wptr_d;
            q_rptr_q   <= q_rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if_pc_q   <= if_pc_d;
        q_instr_q <= q_instr_d;
        q_pc_q    <= q_pc_d;
    end

    assert property (@(posedge clk_i) disable iff (!reset_n_i)
        imem_resp_v_i |-> (out_cnt_q != '0))
        else $error("fe_fetch: response with nothing outstanding");

endmodule
